// File: rtl/msrv32_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master) and imem (slave).
interface msrv32_fetch_buffer_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_gnt_in, imem_rvalid_in, imem_rdata_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_gnt_in, imem_rvalid_in, imem_rdata_in
    );
endinterface

// File: rtl/msrv32_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues imem word requests, buffers returned words in a
// small FIFO and squashes responses that were in flight across a branch/trap redirect.
module msrv32_fetch_buffer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    msrv32_fetch_buffer_if.master imem,
    input  logic                  redirect_in,
    input  logic [31:0]           redirect_pc_in,
    input  logic                  stall_in,
    output logic [31:0]           ms_risc32_mp_instr_out,
    output logic [31:0]           pc_out,
    output logic                  instr_valid_out,
    output logic                  flush_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          flush_q;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic [CW:0]   in_use;
    logic          fire;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;

    // Squashed words still count as outstanding, so the cap also covers them.
    assign in_use    = {1'b0, outstanding} + {1'b0, count};
    assign imem.imem_req_out  = ms_riscv32_mp_rst_in && !redirect_in && (in_use < (CW+1)'(DEPTH));
    assign imem.imem_addr_out = fetch_pc;

    assign fire      = imem.imem_req_out && imem.imem_gnt_in;
    assign rsp       = imem.imem_rvalid_in && (outstanding != '0);
    assign push      = rsp && (discard == '0) && !redirect_in;
    assign pop       = instr_valid_out && !stall_in;
    assign target_pc = {redirect_pc_in[31:2], 2'b00};

    assign instr_valid_out        = (count != '0);
    assign ms_risc32_mp_instr_out = instr_valid_out ? fifo_data[rd_ptr] : NOP_INSTR;
    assign pc_out                 = instr_valid_out ? fifo_pc[rd_ptr] : resp_pc;
    assign flush_out              = flush_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            flush_q     <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(rsp);
            flush_q     <= redirect_in;
            if (redirect_in) begin
                // Everything still in flight after this edge must be dropped on return.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                discard  <= outstanding - CW'(rsp);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem.imem_rdata_in;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_msrv32_fetch_buffer.sv
// Bench for msrv32_fetch_buffer: imem model with scoreboard of granted addresses.
module tb_msrv32_fetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, redirect, stall, resp_hold;
    logic [31:0] redirect_pc;
    logic [31:0] instr, pc;
    logic        valid, flush;
    int          checks = 0;
    int          failures = 0;
    int          consumed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend[$];
    logic        mem_fire = 1'b0;
    logic [31:0] mem_addr = '0;

    logic [31:0] instr2, pc2;
    logic        valid2, flush2;
    logic        f2 = 1'b0;
    logic [31:0] a2 = '0;
    logic [31:0] wrap_q[$];

    always #5 clk = ~clk;

    msrv32_fetch_buffer_if bus();
    msrv32_fetch_buffer_if bus2();

    msrv32_fetch_buffer #(.RESET_PC(32'h0), .DEPTH(2), .NOP_INSTR(NOP)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .imem(bus.master),
        .redirect_in(redirect), .redirect_pc_in(redirect_pc), .stall_in(stall),
        .ms_risc32_mp_instr_out(instr), .pc_out(pc), .instr_valid_out(valid), .flush_out(flush)
    );

    msrv32_fetch_buffer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2), .NOP_INSTR(NOP)) dut_wrap (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .imem(bus2.master),
        .redirect_in(1'b0), .redirect_pc_in(32'h0), .stall_in(1'b0),
        .ms_risc32_mp_instr_out(instr2), .pc_out(pc2), .instr_valid_out(valid2), .flush_out(flush2)
    );

    // Scoreboard: granted addresses are expected back in order; a redirect or reset drops them.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mem_fire = 1'b0;
        end else begin
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_spurious got pc=%h instr=%h, expected no valid output", pc, instr);
                end else begin
                    if (pc !== exp_q[0] || instr !== (exp_q[0] | 32'h13)) begin
                        failures++;
                        $display("FAIL sb_order got pc=%h instr=%h, expected pc=%h instr=%h",
                                 pc, instr, exp_q[0], exp_q[0] | 32'h13);
                    end
                    if (!stall) begin
                        void'(exp_q.pop_front());
                        consumed++;
                    end
                end
            end
            if (redirect) exp_q.delete();
            mem_fire = bus.imem_req_out && bus.imem_gnt_in;
            mem_addr = bus.imem_addr_out;
            if (mem_fire) exp_q.push_back(mem_addr);
            checks++;
            if (exp_q.size() > 2) begin
                failures++;
                $display("FAIL cap in_use=%0d, expected <= 2", exp_q.size());
            end
        end
    end

    // imem model: response one cycle after grant unless held back.
    always @(posedge clk) begin
        #2;
        if (mem_fire) pend.push_back(mem_addr);
        if (!resp_hold && pend.size() != 0) begin
            bus.imem_rvalid_in = 1'b1;
            bus.imem_rdata_in  = pend.pop_front() | 32'h13;
        end else begin
            bus.imem_rvalid_in = 1'b0;
            bus.imem_rdata_in  = 32'h0;
        end
    end

    assign bus2.imem_gnt_in = 1'b1;
    always @(negedge clk) begin
        f2 = bus2.imem_req_out;
        a2 = bus2.imem_addr_out;
        if (f2 && rst_n) wrap_q.push_back(a2);
    end
    always @(posedge clk) begin
        #2;
        bus2.imem_rvalid_in = f2;
        bus2.imem_rdata_in  = a2;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bus.imem_gnt_in = 1'b0;
        resp_hold = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 30 && !(exp_q.size() == 0 && pend.size() == 0 && !valid); i++)
            @(negedge clk);
        checks++;
        if (!(exp_q.size() == 0 && pend.size() == 0 && !valid)) begin
            failures++;
            $display("FAIL drain left=%0d pending=%0d valid=%b, expected 0 0 0", exp_q.size(), pend.size(), valid);
        end
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        resp_hold = 1'b0; bus.imem_gnt_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || flush !== 1'b0 || bus.imem_req_out !== 1'b0) begin
            failures++;
            $display("FAIL reset got v=%b i=%h pc=%h fl=%b req=%b, expected 0 %h 0 0 0",
                     valid, instr, pc, flush, bus.imem_req_out, NOP);
        end
    endtask

    task automatic test_stream();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req_out !== 1'b1 || bus.imem_addr_out !== 32'h0) begin
            failures++;
            $display("FAIL first_req got req=%b addr=%h, expected 1 00000000", bus.imem_req_out, bus.imem_addr_out);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL early_valid got %b, expected 0", valid);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h13) begin
            failures++;
            $display("FAIL first_valid got v=%b pc=%h i=%h, expected 1 00000000 00000013", valid, pc, instr);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (consumed < 8) begin
            failures++;
            $display("FAIL stream_progress got %0d consumed, expected >= 8", consumed);
        end
    endtask

    task automatic test_stall();
        logic [31:0] hold_pc, hold_instr;
        cyc();
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        hold_pc = pc;
        hold_instr = instr;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (bus.imem_req_out !== 1'b0 || valid !== 1'b1 || pc !== hold_pc || instr !== hold_instr) begin
                failures++;
                $display("FAIL stall_hold got req=%b v=%b pc=%h i=%h, expected 0 1 %h %h",
                         bus.imem_req_out, valid, pc, instr, hold_pc, hold_instr);
            end
        end
        cyc();
        stall = 1'b0;
        repeat (10) @(negedge clk);
        drain();
    endtask

    task automatic test_redirect();
        bus.imem_gnt_in = 1'b1; resp_hold = 1'b1;
        cyc();
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        checks++;
        if (bus.imem_req_out !== 1'b0) begin
            failures++;
            $display("FAIL redir_req_mask got %b, expected 0", bus.imem_req_out);
        end
        cyc();
        redirect = 1'b0; resp_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (flush !== 1'b1 || bus.imem_addr_out !== 32'h100 || valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_next got fl=%b addr=%h v=%b, expected 1 00000100 0", flush, bus.imem_addr_out, valid);
        end
        @(negedge clk);
        checks++;
        if (flush !== 1'b0) begin
            failures++;
            $display("FAIL flush_width got %b, expected 0", flush);
        end
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h113) begin
            failures++;
            $display("FAIL redir_first got v=%b pc=%h i=%h, expected 1 00000100 00000113", valid, pc, instr);
        end
        drain();
    endtask

    task automatic test_redirect_rvalid();
        bus.imem_gnt_in = 1'b1;
        cyc();
        bus.imem_gnt_in = 1'b0; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (bus.imem_rvalid_in !== 1'b1) begin
            failures++;
            $display("FAIL coinc_setup got rvalid=%b, expected 1", bus.imem_rvalid_in);
        end
        cyc();
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h100 || flush !== 1'b1) begin
            failures++;
            $display("FAIL coinc_drop got v=%b i=%h pc=%h fl=%b, expected 0 %h 00000100 1", valid, instr, pc, flush, NOP);
        end
        cyc();
        bus.imem_gnt_in = 1'b1;
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h113) begin
            failures++;
            $display("FAIL coinc_first got v=%b pc=%h i=%h, expected 1 00000100 00000113", valid, pc, instr);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; bus.imem_gnt_in = 1'b1; resp_hold = 1'b0;
        cyc();
        cyc();
        bus.imem_gnt_in = 1'b0; resp_hold = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pend.size() != 1) begin
            failures++;
            $display("FAIL mid_setup got v=%b pending=%0d, expected 1 1", valid, pend.size());
        end
        cyc();
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || instr !== NOP || pc !== 32'h0 || flush !== 1'b0 || bus.imem_req_out !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b i=%h pc=%h fl=%b req=%b, expected 0 %h 0 0 0",
                     valid, instr, pc, flush, bus.imem_req_out, NOP);
        end
        cyc();
        rst_n = 1'b1; resp_hold = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_rvalid_in !== 1'b1) begin
            failures++;
            $display("FAIL stray_setup got rvalid=%b, expected 1", bus.imem_rvalid_in);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || pc !== 32'h0) begin
                failures++;
                $display("FAIL stray_ignored got v=%b pc=%h, expected 0 00000000", valid, pc);
            end
        end
        cyc();
        bus.imem_gnt_in = 1'b1;
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h13) begin
            failures++;
            $display("FAIL post_reset got v=%b pc=%h i=%h, expected 1 00000000 00000013", valid, pc, instr);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        checks++;
        if (wrap_q.size() < 3) begin
            failures++;
            $display("FAIL wrap_count got %0d grants, expected >= 3", wrap_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wrap_q[i] !== want[i]) begin
                    failures++;
                    $display("FAIL wrap_addr%0d got %h, expected %h", i, wrap_q[i], want[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
